lg_shift_seq: RTL

- Multi-bit shift sequencer built around the team's single-step lane shifter lg_shifter (16-bit, one-position logical shift, lane mode selected by bitnum).
- Accepts one operand plus a 4-bit shift amount over a valid/ready handshake.
- Applies lg_shifter iteratively, one position per clock, to a held working register, then presents the result over a second valid/ready handshake.
- Sits between the ALU issue logic and the shifter datapath; it replaces direct single-step use for SHL/SHR with arbitrary amounts.

---
 rtl/lg_pkg.sv | 69 ++++++
 rtl/lg_shifter.sv | 32 +++
 rtl/lg_shift_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lg_pkg.sv
// ---------------------------------------------------------------------------
// lg_pkg
// Shared definitions for the lane shifter datapath:
//   - lane-mode encodings carried on the 2-bit bitnum field
//   - state encoding of the multi-step shift sequencer
//   - helpers mapping a lane mode to its width, boundary masks and the
//     effective number of single-position steps for a request
// ---------------------------------------------------------------------------
package lg_pkg;

  localparam int unsigned DATA_W = 16;

  // Lane modes. Encoding 2'b11 is not listed; every consumer treats it as
  // LANE8.
  localparam logic [1:0] LANE4  = 2'b00;
  localparam logic [1:0] LANE8  = 2'b01;
  localparam logic [1:0] LANE16 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Width in bits of one lane for the given mode (4, 8 or 16).
  function automatic logic [4:0] lane_width(input logic [1:0] bitnum);
    case (bitnum)
      LANE4:   return 5'd4;
      LANE16:  return 5'd16;
      default: return 5'd8;
    endcase
  endfunction

  // Bit positions that are the least-significant bit of a lane. A left shift
  // must clear these, otherwise the MSB of the lane below would leak in.
  function automatic logic [DATA_W-1:0] lane_lsb_mask(input logic [1:0] bitnum);
    case (bitnum)
      LANE4:   return 16'h1111;
      LANE16:  return 16'h0001;
      default: return 16'h0101;
    endcase
  endfunction

  // Bit positions that are the most-significant bit of a lane. A right shift
  // must clear these, otherwise the LSB of the lane above would leak in.
  function automatic logic [DATA_W-1:0] lane_msb_mask(input logic [1:0] bitnum);
    case (bitnum)
      LANE4:   return 16'h8888;
      LANE16:  return 16'h8000;
      default: return 16'h8080;
    endcase
  endfunction

  // Number of single-position steps the sequencer performs for a request.
  // With clamping, shifting past the lane width is pointless (the lane is
  // already zero), so the count saturates at the lane width. shamt never
  // exceeds 15, so a 16-bit lane never clamps and 4 bits always suffice.
  function automatic logic [3:0] effective_count(input logic [3:0] shamt,
                                                 input logic [1:0] bitnum,
                                                 input logic       clamp);
    logic [4:0] width;
    width = lane_width(bitnum);
    if (clamp && ({1'b0, shamt} > width)) begin
      return width[3:0];
    end
    return shamt;
  endfunction

endpackage

// File: rtl/lg_shifter.sv
// ---------------------------------------------------------------------------
// lg_shifter
// Combinational single-step lane shifter: shifts a 16-bit word by exactly
// one position, logically (zero fill), independently within each lane.
//
// Ports:
//   datain   [15:0]  operand
//   right            1 = shift toward LSB, 0 = toward MSB
//   bitnum   [1:0]   lane mode: 00 = 4x4, 01 = 2x8, 10 = 1x16, 11 = as 01
//   dataout  [15:0]  shifted word
// ---------------------------------------------------------------------------
module lg_shifter
  import lg_pkg::*;
(
  input  logic [DATA_W-1:0] datain,
  input  logic              right,
  input  logic [1:0]        bitnum,
  output logic [DATA_W-1:0] dataout
);

  logic [DATA_W-1:0] shl_full;
  logic [DATA_W-1:0] shr_full;

  // Shift the whole word, then clear the bit positions that just received
  // a bit from the neighbouring lane.
  assign shl_full = {datain[DATA_W-2:0], 1'b0};
  assign shr_full = {1'b0, datain[DATA_W-1:1]};

  assign dataout = right ? (shr_full & ~lane_msb_mask(bitnum))
                         : (shl_full & ~lane_lsb_mask(bitnum));

endmodule

// File: rtl/lg_shift_seq.sv
// ---------------------------------------------------------------------------
// lg_shift_seq
// Multi-bit lane shift sequencer. Accepts an operand and a 4-bit shift
// amount, then applies lg_shifter one position per clock to a held working
// register and presents the result. One request is in flight at a time.
//
// Parameters:
//   CLAMP      1 = step count saturates at the lane width (same result,
//                  shorter latency); 0 = always shamt steps
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-high reset
//   in_valid / in_ready request handshake (in_ready high only in IDLE)
//   datain   [15:0]     operand, sampled at accept
//   right               1 = logical right, 0 = left (sampled at accept)
//   bitnum   [1:0]      lane mode (sampled at accept)
//   shamt    [3:0]      shift amount 0..15 (sampled at accept)
//   out_valid/out_ready result handshake
//   dataout  [15:0]     result, held while out_valid && !out_ready
//   busy                high while a request is in SHIFT or DONE
// ---------------------------------------------------------------------------
module lg_shift_seq
  import lg_pkg::*;
#(
  parameter bit CLAMP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  input  logic              right,
  input  logic [1:0]        bitnum,
  input  logic [3:0]        shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              busy
);

  state_t            state_q,  state_d;
  logic [DATA_W-1:0] work_q,   work_d;
  logic [3:0]        count_q,  count_d;
  logic              right_q,  right_d;
  logic [1:0]        bitnum_q, bitnum_d;

  logic [DATA_W-1:0] shifted;
  logic [3:0]        load_count;

  // The shifter always sees the working register and the request's latched
  // direction/mode, so later changes on the request inputs cannot disturb
  // an operation in progress.
  lg_shifter u_shifter (
    .datain  (work_q),
    .right   (right_q),
    .bitnum  (bitnum_q),
    .dataout (shifted)
  );

  assign load_count = effective_count(shamt, bitnum, CLAMP);

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    right_d  = right_q;
    bitnum_d = bitnum_q;

    unique case (state_q)
      IDLE: begin
        // in_ready is high in IDLE, so in_valid alone means accept.
        // out_ready has no meaning here and is deliberately not looked at.
        if (in_valid) begin
          work_d   = datain;
          right_d  = right;
          bitnum_d = bitnum;
          count_d  = load_count;
          state_d  = (load_count == 4'd0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        work_d  = shifted;
        count_d = count_q - 4'd1;
        // The last step and the move to DONE share one edge. The <= also
        // guards against a zero count, which the load logic never produces.
        if (count_q <= 4'd1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Hold the result until the consumer takes it; in_valid is ignored
        // because in_ready is low.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: the working register and counter are reset too, not just the state,
  // so dataout and any debug view of the datapath come up at a known zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= '0;
      right_q  <= 1'b0;
      bitnum_q <= LANE4;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      right_q  <= right_d;
      bitnum_q <= bitnum_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (Moore, straight from the state register)
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // Intermediate shift values are not exposed; outside DONE the bus is zero.
  assign dataout   = out_valid ? work_q : '0;

endmodule
